inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//  Instruction-fetch stage of the multicycle MIPS core; sits directly upstream of the main decoder/control unit.
//  Holds the PC, fetches one 32-bit word per instruction over a req/ack handshake to instruction memory, and latches it in an IR.
//  Presents opcode/funct fields to decode with a valid/ready handshake.
//  Computes next PC from decode's branch/branchn/jump strobes and the ALU zero flag.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset
// PORTS
//  clk         in   1   single clock, all state on rising edge
//  rst         in   1   synchronous, active-low reset (0 = reset)
//  imem_req    out  1   fetch request, held high until ack
//  imem_addr   out  32  fetch byte address (= pc), stable while imem_req=1
//  imem_ack    in   1   memory accepts request; imem_rdata valid same cycle
//  imem_rdata  in   32  fetched instruction word
//  inst_valid  out  1   IR holds an instruction for decode
//  id_ready    in   1   decode/execute done with current instruction; next PC inputs valid
//  inst        out  32  instruction register
//  ct_inst     out  6   opcode to control: inst[31:26] when inst_valid, else 6'h3F (bubble)
//  aluct_inst  out  6   funct to ALU control: inst[5:0] when inst_valid, else 6'h00
//  pc          out  32  PC of current instruction
//  pc_plus4    out  32  pc + 4 (mod 2^32)
//  ct_branch   in   1   beq strobe from control
//  ct_branchn  in   1   bne strobe from control
//  ct_jump     in   1   j strobe from control
//  alu_zero    in   1   ALU zero flag for current instruction
// BEHAVIOUR
//  Reset (rst=0 at posedge): pc=RESET_PC; state=S_FETCH; imem_req=0; inst=0; inst_valid=0; counter=0.
//    Any outstanding request is abandoned at that edge.
//  States: S_FETCH (first cycle after reset/issue), S_WAIT, S_ISSUE.
//  S_FETCH: imem_req<=1, go S_WAIT.
//  S_WAIT:
//    - imem_req=1, imem_addr=pc.
//    - On imem_ack=1: inst<=imem_rdata, inst_valid<=1, imem_req<=0, go S_ISSUE; else stay.
//    - imem_ack while imem_req=0 is ignored.
//  S_ISSUE: inst_valid=1, IR frozen.
//    - On id_ready=1: pc<=next_pc, inst_valid<=0, go S_FETCH.
//    - Otherwise hold indefinitely.
//  next_pc, priority high to low:
//    1. ct_jump -> {pc_plus4[31:28], inst[25:0], 2'b00}
//    2. (ct_branch & alu_zero) | (ct_branchn & ~alu_zero) -> pc_plus4 + (sext(inst[15:0]) << 2)
//    3. otherwise pc_plus4
//  Strobes are sampled only in S_ISSUE with id_ready=1; ignored otherwise. All adds are 32-bit and wrap (pc 32'hFFFF_FFFC -> 0).
//  Latency: ack in the first S_WAIT cycle -> inst_valid 2 cycles after issue edge; best-case throughput 1 instr / 3 cycles.
//  Bubble opcode 6'h3F decodes to no instruction in control -> all write/mem enables low while fetching.
// CONFIGURATION
//  IF_PERF_CNT_EN defined:
//    - adds out ports fetch_cnt[31:0] (instructions issued = id_ready handshakes) and stall_cnt[31:0] (cycles in S_WAIT with imem_ack=0).
//    - Both reset to 0 and wrap.
//  IF_PERF_CNT_EN undefined: ports and logic absent; all other behaviour identical.
// STRUCTURE
//  Shared include mips_defs.vh:
//    - state encodings S_FETCH=2'd0, S_WAIT=2'd1, S_ISSUE=2'd2
//    - OPC_BUBBLE=6'h3F, OPC_J=6'h02, OPC_BEQ=6'h04, OPC_BNE=6'h05
//  Sub-module next_pc_calc (combinational): inputs pc_plus4, inst[25:0], ct_jump, ct_branch, ct_branchn, alu_zero; output next_pc.
// TESTING
//  1. Reset with RESET_PC=32'h100, ack on the first S_WAIT cycle, id_ready=1 each S_ISSUE -> imem_addr sequence 0x100, 0x104, 0x108; inst_valid pulses every 3rd cycle.
//  2. Ack delayed 4 cycles -> imem_req and imem_addr held; ct_inst=6'h3F throughout; no PC change.
//  3. Fetch beq, imm 16'hFFFE, alu_zero=1 at pc=0x200 -> next imem_addr=0x1FC.
//     Same with alu_zero=0 -> 0x204.
//     bne, imm 16'h0003, alu_zero=0 -> 0x210.
//  4. j with inst[25:0]=26'h0000040 at pc=0x3000_0000, also ct_branch=1 & alu_zero=1 -> jump wins, next addr 0x3000_0100.
//  5. id_ready=0 for 5 cycles in S_ISSUE -> inst, ct_inst, pc stable.
//     pc=0xFFFF_FFFC, no branch -> next addr 0x0000_0000.
//  6. rst=0 while S_WAIT -> imem_req=0 and inst_valid=0 after that edge; pc=RESET_PC; late ack ignored.
//     With IF_PERF_CNT_EN: fetch_cnt=0, stall_cnt=0.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared state encodings, opcodes and offset helper for the fetch stage
package inst_fetch_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2
  } if_state_e;

  localparam logic [5:0] OPC_BUBBLE = 6'h3F;
  localparam logic [5:0] OPC_J      = 6'h02;
  localparam logic [5:0] OPC_BEQ    = 6'h04;
  localparam logic [5:0] OPC_BNE    = 6'h05;

  // Sign-extended word offset of a branch immediate, already scaled to bytes.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_next_pc_calc.sv
// rtl/inst_fetch_next_pc_calc.sv - combinational next-PC selection (jump > taken branch > sequential)
module next_pc_calc
  import inst_fetch_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [25:0] inst,
  input  logic        ct_jump,
  input  logic        ct_branch,
  input  logic        ct_branchn,
  input  logic        alu_zero,
  output logic [31:0] next_pc
);

  logic branch_taken;

  assign branch_taken = (ct_branch & alu_zero) | (ct_branchn & ~alu_zero);

  // Jump keeps the upper nibble of the sequential PC; branch offsets wrap at 32 bits.
  always_comb begin
    next_pc = pc_plus4;
    if (ct_jump) begin
      next_pc = {pc_plus4[31:28], inst, 2'b00};
    end else if (branch_taken) begin
      next_pc = pc_plus4 + branch_offset(inst[15:0]);
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - multicycle fetch stage: PC, imem req/ack, IR and decode handshake; IF_PERF_CNT_EN adds fetch/stall counters
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        id_ready,
  output logic [31:0] inst,
  output logic [5:0]  ct_inst,
  output logic [5:0]  aluct_inst,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        ct_branch,
  input  logic        ct_branchn,
  input  logic        ct_jump,
  input  logic        alu_zero
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
`endif
);

  if_state_e   state;
  if_state_e   state_nxt;
  logic        load_ir;
  logic        advance;
  logic [31:0] next_pc;

  // State register; reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus the req/valid strobes, which are pure functions of state.
  always_comb begin
    state_nxt  = state;
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    load_ir    = 1'b0;
    advance    = 1'b0;
    case (state)
      S_FETCH: begin
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          load_ir   = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        inst_valid = 1'b1;
        if (id_ready) begin
          advance   = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      default: begin
        state_nxt = S_FETCH;
      end
    endcase
  end

  // PC advances only on the decode handshake; IR loads only on an accepted fetch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc   <= RESET_PC;
      inst <= 32'h0;
    end else begin
      if (load_ir) begin
        inst <= imem_rdata;
      end
      if (advance) begin
        pc <= next_pc;
      end
    end
  end

  assign imem_addr  = pc;
  assign pc_plus4   = pc + 32'd4;
  assign ct_inst    = inst_valid ? inst[31:26] : OPC_BUBBLE;
  assign aluct_inst = inst_valid ? inst[5:0]   : 6'h00;

  next_pc_calc u_next_pc_calc (
    .pc_plus4   (pc_plus4),
    .inst       (inst[25:0]),
    .ct_jump    (ct_jump),
    .ct_branch  (ct_branch),
    .ct_branchn (ct_branchn),
    .alu_zero   (alu_zero),
    .next_pc    (next_pc)
  );

`ifdef IF_PERF_CNT_EN
  // Issued-instruction and memory-stall counters, free-running and wrapping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_cnt <= 32'h0;
      stall_cnt <= 32'h0;
    end else begin
      if (advance) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (imem_req && !imem_ack) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed self-checking bench for inst_fetch
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        id_ready;
  logic [31:0] inst;
  logic [5:0]  ct_inst;
  logic [5:0]  aluct_inst;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        ct_branch;
  logic        ct_branchn;
  logic        ct_jump;
  logic        alu_zero;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] NOP_ADD = 32'h0000_0020;

  inst_fetch #(.RESET_PC(32'h0000_0100)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .id_ready   (id_ready),
    .inst       (inst),
    .ct_inst    (ct_inst),
    .aluct_inst (aluct_inst),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .ct_branch  (ct_branch),
    .ct_branchn (ct_branchn),
    .ct_jump    (ct_jump),
    .alu_zero   (alu_zero)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt  (fetch_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Waits for a request, optionally stalls, then acks with word; returns address and wait gap.
  task automatic fetch(input int delay, input logic [31:0] word,
                       output logic [31:0] addr, output int gap);
    gap = 0;
    while (imem_req !== 1'b1 && gap < 20) begin
      @(negedge clk);
      gap++;
    end
    if (imem_req !== 1'b1) check("req_timeout", {31'b0, imem_req}, 32'd1);
    addr = imem_addr;
    for (int i = 0; i < delay; i++) begin
      check("stall_req", {31'b0, imem_req}, 32'd1);
      check("stall_addr", imem_addr, addr);
      check("stall_pc", pc, addr);
      check("stall_bubble", {26'b0, ct_inst}, {26'b0, OPC_BUBBLE});
      @(negedge clk);
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
  endtask

  task automatic issue(input logic j, input logic b, input logic bn, input logic z);
    ct_jump    = j;
    ct_branch  = b;
    ct_branchn = bn;
    alu_zero   = z;
    id_ready   = 1'b1;
    @(negedge clk);
    id_ready   = 1'b0;
    ct_jump    = 1'b0;
    ct_branch  = 1'b0;
    ct_branchn = 1'b0;
    alu_zero   = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] exp_seq [3];
    int          g;

    exp_seq[0] = 32'h100;
    exp_seq[1] = 32'h104;
    exp_seq[2] = 32'h108;

    rst = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; id_ready = 1'b0;
    ct_branch = 1'b0; ct_branchn = 1'b0; ct_jump = 1'b0; alu_zero = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_inst", inst, 32'h0);
    check("rst_pc", pc, 32'h100);
    check("rst_pc_plus4", pc_plus4, 32'h104);
    check("rst_ct_inst", {26'b0, ct_inst}, 32'h3F);
    check("rst_aluct", {26'b0, aluct_inst}, 32'h0);
`ifdef IF_PERF_CNT_EN
    check("rst_fetch_cnt", fetch_cnt, 32'h0);
    check("rst_stall_cnt", stall_cnt, 32'h0);
`endif
    rst = 1'b1;

    // Sequential fetches with immediate ack; last one is a jump to 0x200.
    for (int k = 0; k < 3; k++) begin
      fetch(0, (k == 2) ? {OPC_J, 26'h80} : NOP_ADD, a, g);
      check("seq_addr", a, exp_seq[k]);
      check("seq_gap", g, 32'd1);
      check("seq_valid", {31'b0, inst_valid}, 32'd1);
      issue(k == 2, 1'b0, 1'b0, 1'b0);
      check("seq_valid_drop", {31'b0, inst_valid}, 32'd0);
    end

    // Delayed ack on beq -8, taken.
    fetch(4, {OPC_BEQ, 5'd1, 5'd2, 16'hFFFE}, a, g);
    check("jump_addr", a, 32'h200);
    check("beq_ct_inst", {26'b0, ct_inst}, {26'b0, OPC_BEQ});
    check("beq_inst", inst, {OPC_BEQ, 5'd1, 5'd2, 16'hFFFE});
    issue(1'b0, 1'b1, 1'b0, 1'b1);
`ifdef IF_PERF_CNT_EN
    check("perf_fetch_cnt", fetch_cnt, 32'd4);
    check("perf_stall_cnt", stall_cnt, 32'd4);
`endif
    fetch(0, NOP_ADD, a, g);
    check("beq_taken_addr", a, 32'h1FC);
    issue(1'b0, 1'b0, 1'b0, 1'b0);
    fetch(0, {OPC_BEQ, 5'd1, 5'd2, 16'hFFFE}, a, g);
    check("seq_1fc_addr", a, 32'h200);
    issue(1'b0, 1'b1, 1'b0, 1'b0);
    fetch(0, {OPC_J, 26'h80}, a, g);
    check("beq_not_taken_addr", a, 32'h204);
    issue(1'b1, 1'b0, 1'b0, 1'b0);
    fetch(0, {OPC_BNE, 5'd3, 5'd4, 16'h0003}, a, g);
    check("jump_back_addr", a, 32'h200);
    issue(1'b0, 1'b0, 1'b1, 1'b0);

    // Decode holds off for 5 cycles: IR and PC must stay frozen.
    fetch(0, NOP_ADD, a, g);
    check("bne_taken_addr", a, 32'h210);
    for (int i = 0; i < 5; i++) begin
      check("hold_inst", inst, NOP_ADD);
      check("hold_ct_inst", {26'b0, ct_inst}, 32'h0);
      check("hold_aluct", {26'b0, aluct_inst}, 32'h20);
      check("hold_pc", pc, 32'h210);
      check("hold_valid", {31'b0, inst_valid}, 32'd1);
      @(negedge clk);
    end
    issue(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset while waiting on memory, then a stray ack while no request is out.
    g = 0;
    while (imem_req !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("pre_rst_addr", imem_addr, 32'h214);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("mid_rst_req", {31'b0, imem_req}, 32'd0);
    check("mid_rst_valid", {31'b0, inst_valid}, 32'd0);
    check("mid_rst_pc", pc, 32'h100);
`ifdef IF_PERF_CNT_EN
    check("mid_rst_fetch_cnt", fetch_cnt, 32'h0);
    check("mid_rst_stall_cnt", stall_cnt, 32'h0);
`endif
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    check("late_ack_valid", {31'b0, inst_valid}, 32'd0);
    check("late_ack_req", {31'b0, imem_req}, 32'd1);
    check("late_ack_inst", inst, 32'h0);

    // Backward branch from 0x100 wraps below zero, then sequential wraps to 0.
    fetch(0, {OPC_BEQ, 10'd0, 16'hFFBE}, a, g);
    check("post_rst_addr", a, 32'h100);
    issue(1'b0, 1'b1, 1'b0, 1'b1);
    fetch(0, NOP_ADD, a, g);
    check("wrap_hi_addr", a, 32'hFFFF_FFFC);
    check("wrap_pc_plus4", pc_plus4, 32'h0);
    issue(1'b0, 1'b0, 1'b0, 1'b0);

    // Climb to 0x3000_0000 with maximal forward branches (+0x20000 each).
    for (int k = 0; k < 6144; k++) begin
      fetch(0, {OPC_BEQ, 10'd0, 16'h7FFF}, a, g);
      if (k == 0) check("wrap_zero_addr", a, 32'h0);
      issue(1'b0, 1'b1, 1'b0, 1'b1);
    end

    // Jump beats a simultaneously taken branch.
    fetch(0, {OPC_J, 26'h0000040}, a, g);
    check("climb_addr", a, 32'h3000_0000);
    issue(1'b1, 1'b1, 1'b0, 1'b1);
    fetch(0, NOP_ADD, a, g);
    check("jump_priority_addr", a, 32'h3000_0100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
